// File: rtl/multicycle_main_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_main_ctrl
//
// Main control FSM for a multicycle MIPS datapath. It sequences each instruction
// through fetch, decode, execute, memory and writeback, and drives the datapath
// enables, the mux selects and the ALUOp code consumed by the ALU controller.
// The FSM waits in the memory-access states until mem_ready_i is high.
//
// Optional feature (compile-time macro):
//   JUMP_EN  - when defined, OP_J is decoded into a JUMP state that writes the
//              PC from the jump target. When undefined, OP_J is an illegal
//              opcode, the JUMP state does not exist and pc_source_o never
//              selects the jump target.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous reset, active-high
//   op_i             opcode IR[31:26], sampled in DECODE
//   mem_ready_i      memory done this cycle (read data valid / write accepted)
//   pc_write_o       unconditional PC write
//   pc_write_cond_o  PC write if ALU zero
//   iord_o           memory address select: 0=PC 1=ALUOut
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   ir_write_o       load instruction register
//   mem_to_reg_o     regfile write data: 1=MDR 0=ALUOut
//   reg_dst_o        regfile write address: 1=rd 0=rt
//   reg_write_o      regfile write enable
//   alu_src_a_o      ALU A: 0=PC 1=rs
//   alu_src_b_o      ALU B: 00=rt 01=4 10=imm 11=imm<<2
//   pc_source_o      PC source: 00=ALU 01=ALUOut 10=jump target
//   ALUOp_o          000 R-type, 001 add, 010 sub (beq), 011 addi, 100 slti
//   illegal_o        one-cycle pulse in DECODE on an unsupported opcode
//   state_o          current state code (debug)
// ----------------------------------------------------------------------------
module multicycle_main_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_SLTI  = 6'h0A,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o,
    output logic [2:0] ALUOp_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRex      = 4'd6,
        StRwb      = 4'd7,
        StBranch   = 4'd8,
        StImmEx    = 4'd9,
`ifdef JUMP_EN
        StJump     = 4'd11,
`endif
        StImmWb    = 4'd10
    } state_e;

    localparam logic [2:0] AluRtype = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b001;
    localparam logic [2:0] AluSub   = 3'b010;
    localparam logic [2:0] AluAddi  = 3'b011;
    localparam logic [2:0] AluSlti  = 3'b100;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [2:0] imm_alu_op;

    // Immediate-class ALU code is held through IMMEX and IMMWB.
    assign imm_alu_op = (op_q == OP_SLTI) ? AluSlti : AluAddi;

    assign state_o = state_q;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        pc_source_o     = 2'b00;
        ALUOp_o         = AluAdd;
        illegal_o       = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC+4 is computed every fetch cycle, but IR and PC only
                // commit on the cycle the memory returns the instruction.
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Precompute the branch target while the opcode is decoded.
                alu_src_b_o = 2'b11;
                op_d        = op_i;
                state_d     = StFetch;
                if (op_i == OP_RTYPE) begin
                    state_d = StRex;
                end else if (op_i == OP_LW || op_i == OP_SW) begin
                    state_d = StMemAddr;
                end else if (op_i == OP_BEQ) begin
                    state_d = StBranch;
                end else if (op_i == OP_ADDI || op_i == OP_SLTI) begin
                    state_d = StImmEx;
                end else if (op_i == OP_J) begin
`ifdef JUMP_EN
                    state_d = StJump;
`else
                    illegal_o = 1'b1;
`endif
                end else begin
                    illegal_o = 1'b1;
                end
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (op_q == OP_LW) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    state_d = StFetch;
                end
            end
            StRex: begin
                alu_src_a_o = 1'b1;
                ALUOp_o     = AluRtype;
                state_d     = StRwb;
            end
            StRwb: begin
                // Keep the R-type function code on the ALU while ALUOut is written.
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                ALUOp_o     = AluRtype;
                state_d     = StFetch;
            end
            StBranch: begin
                alu_src_a_o     = 1'b1;
                ALUOp_o         = AluSub;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                state_d         = StFetch;
            end
            StImmEx: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ALUOp_o     = imm_alu_op;
                state_d     = StImmWb;
            end
            StImmWb: begin
                reg_write_o = 1'b1;
                ALUOp_o     = imm_alu_op;
                state_d     = StFetch;
            end
`ifdef JUMP_EN
            StJump: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
                state_d     = StFetch;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset aborts the instruction in flight: nothing may be written.
        if (rst_i) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            iord_o          = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            ir_write_o      = 1'b0;
            mem_to_reg_o    = 1'b0;
            reg_dst_o       = 1'b0;
            reg_write_o     = 1'b0;
            alu_src_a_o     = 1'b0;
            alu_src_b_o     = 2'b00;
            pc_source_o     = 2'b00;
            ALUOp_o         = AluAdd;
            illegal_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl. Instructions are expanded into per-cycle
// expectation records (inputs to apply plus outputs required) from the
// instruction-level rules; one process applies each record and compares.
module tb_multicycle_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] op_i = 6'h00;
    logic       mem_ready_i = 1'b0;
    logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
    logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, pc_source_o;
    logic [2:0] alu_op_o;
    logic       illegal_o;
    logic [3:0] state_o;

    multicycle_main_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .op_i            (op_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .iord_o          (iord_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .pc_source_o     (pc_source_o),
        .ALUOp_o         (alu_op_o),
        .illegal_o       (illegal_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcs;
        logic [2:0] alu;
        logic       ill;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        outs_t      o;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    cyc_t cur;
    outs_t act;

    function automatic outs_t idle();
        outs_t o = '0;
        o.alu = 3'b001;
        return o;
    endfunction

    function automatic logic [5:0] junk_op();
        return 6'($urandom);
    endfunction

    function automatic logic junk_rdy();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A: return 1'b1;
`ifdef JUMP_EN
            6'h02: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input outs_t o);
        cyc_t c;
        c.rst = rst; c.op = op; c.rdy = rdy; c.st = st; c.o = o;
        q.push_back(c);
    endtask

    task automatic fetch(input int fstall);
        outs_t o;
        for (int i = 0; i < fstall; i++) begin
            o = idle(); o.mr = 1'b1; o.srcb = 2'b01;
            push(1'b0, junk_op(), 1'b0, 4'd0, o);
        end
        o = idle(); o.mr = 1'b1; o.srcb = 2'b01; o.irw = 1'b1; o.pcw = 1'b1;
        push(1'b0, junk_op(), 1'b1, 4'd0, o);
    endtask

    // Memory access phase: wait cycles with ready low, then the ready cycle.
    task automatic mem_phase(input logic [3:0] st, input bit wr, input int mstall);
        outs_t o;
        o = idle(); o.iord = 1'b1;
        if (wr) o.mw = 1'b1; else o.mr = 1'b1;
        for (int i = 0; i < mstall; i++) push(1'b0, junk_op(), 1'b0, st, o);
        push(1'b0, junk_op(), 1'b1, st, o);
    endtask

    task automatic gen(input logic [5:0] op, input int fstall, input int mstall);
        outs_t o;
        fetch(fstall);
        o = idle(); o.srcb = 2'b11; o.ill = !legal(op);
        push(1'b0, op, junk_rdy(), 4'd1, o);
        if (!legal(op)) return;
        case (op)
            6'h00: begin
                o = idle(); o.srca = 1'b1; o.alu = 3'b000;
                push(1'b0, junk_op(), junk_rdy(), 4'd6, o);
                o = idle(); o.rw = 1'b1; o.rdst = 1'b1; o.alu = 3'b000;
                push(1'b0, junk_op(), junk_rdy(), 4'd7, o);
            end
            6'h23, 6'h2B: begin
                o = idle(); o.srca = 1'b1; o.srcb = 2'b10;
                push(1'b0, junk_op(), junk_rdy(), 4'd2, o);
                if (op == 6'h23) begin
                    mem_phase(4'd3, 1'b0, mstall);
                    o = idle(); o.rw = 1'b1; o.m2r = 1'b1;
                    push(1'b0, junk_op(), junk_rdy(), 4'd4, o);
                end else begin
                    mem_phase(4'd5, 1'b1, mstall);
                end
            end
            6'h04: begin
                o = idle(); o.srca = 1'b1; o.alu = 3'b010; o.pwc = 1'b1; o.pcs = 2'b01;
                push(1'b0, junk_op(), junk_rdy(), 4'd8, o);
            end
            6'h08, 6'h0A: begin
                o = idle(); o.srca = 1'b1; o.srcb = 2'b10;
                o.alu = (op == 6'h0A) ? 3'b100 : 3'b011;
                push(1'b0, junk_op(), junk_rdy(), 4'd9, o);
                o = idle(); o.rw = 1'b1;
                o.alu = (op == 6'h0A) ? 3'b100 : 3'b011;
                push(1'b0, junk_op(), junk_rdy(), 4'd10, o);
            end
            default: begin
                o = idle(); o.pcw = 1'b1; o.pcs = 2'b10;
                push(1'b0, junk_op(), junk_rdy(), 4'd11, o);
            end
        endcase
    endtask

    task automatic pin(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act_v, exp_v);
        end
    endtask

    // Apply one record per cycle and compare the DUT against it.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            rst_i       = cur.rst;
            op_i        = cur.op;
            mem_ready_i = cur.rdy;
            #1;
            act = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
                   ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                   alu_src_b_o, pc_source_o, alu_op_o, illegal_o};
            checks++;
            if (state_o !== cur.st) begin
                errors++;
                $display("FAIL state cyc%0d got=%0d expected=%0d", cyc_n, state_o, cur.st);
            end
            checks++;
            if (act !== cur.o) begin
                errors++;
                $display("FAIL outputs cyc%0d state=%0d got=%05h expected=%05h",
                         cyc_n, cur.st, act, cur.o);
            end
            cyc_n++;
        end
    end

    initial begin
        int    base;
        int    budget;
        outs_t o;

        push(1'b1, 6'h00, 1'b0, 4'd0, idle());
        push(1'b1, 6'h00, 1'b1, 4'd0, idle());

        base = q.size(); gen(6'h00, 0, 0);
        pin("rtype_len", q.size() - base, 4);
        pin("rtype_rex_state", int'(q[base+2].st), 6);
        pin("rtype_rwb_aluop", int'(q[base+3].o.alu), 0);
        pin("rtype_rwb_regdst", int'(q[base+3].o.rdst), 1);
        gen(6'h00, 2, 0);

        base = q.size(); gen(6'h23, 0, 3);
        pin("lw_len", q.size() - base, 8);
        pin("lw_last_read_state", int'(q[base+6].st), 3);
        pin("lw_memwb_state", int'(q[base+7].st), 4);
        pin("lw_memwb_memtoreg", int'(q[base+7].o.m2r), 1);
        gen(6'h23, 0, 0);
        gen(6'h2B, 1, 0);
        gen(6'h2B, 0, 2);

        base = q.size(); gen(6'h04, 0, 0);
        pin("beq_len", q.size() - base, 3);
        pin("beq_aluop", int'(q[base+2].o.alu), 2);
        pin("beq_pcsource", int'(q[base+2].o.pcs), 1);

        gen(6'h08, 0, 0);
        base = q.size(); gen(6'h0A, 0, 0);
        pin("slti_ex_aluop", int'(q[base+2].o.alu), 4);
        pin("slti_wb_aluop", int'(q[base+3].o.alu), 4);

        base = q.size(); gen(6'h3F, 0, 0);
        pin("illegal_len", q.size() - base, 2);
        pin("illegal_pulse", int'(q[base+1].o.ill), 1);

        base = q.size(); gen(6'h02, 0, 0);
`ifdef JUMP_EN
        pin("jump_len", q.size() - base, 3);
`else
        pin("jump_off_len", q.size() - base, 2);
`endif

        // Store interrupted by reset while waiting for memory.
        fetch(0);
        o = idle(); o.srcb = 2'b11;
        push(1'b0, 6'h2B, 1'b0, 4'd1, o);
        o = idle(); o.srca = 1'b1; o.srcb = 2'b10;
        push(1'b0, junk_op(), 1'b0, 4'd2, o);
        o = idle(); o.mw = 1'b1; o.iord = 1'b1;
        push(1'b0, junk_op(), 1'b0, 4'd5, o);
        push(1'b1, junk_op(), 1'b0, 4'd5, idle());
        gen(6'h00, 0, 0);
        gen(6'h08, 1, 0);
        gen(6'h2B, 0, 0);

        budget = 5000;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
